elevator_ctrl_n: RTL and testbench

Parametrised N-floor elevator controller, next generation of the 3-floor elevator FSM. It latches hall/cabin calls per floor and serves them in collective (sweep) order: it keeps travelling in one direction while calls remain ahead, then reverses. It sequences the door open/close handshake and drives the two-bit engine command to the motor driver. Floor position is tracked internally by a per-floor travel timer.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_call_reg.sv | 40 ++++
 rtl/elevator_ctrl_n.sv | 216 +++++++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the N-floor elevator controller.
// Optional emergency-recall feature is enabled by defining ELEVATOR_EMERGENCY_EN.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DN,
    DOOR_OPEN,
    DOOR_CLOSE
  } state_e;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DN   = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/elevator_call_reg.sv
// Latched per-floor call register with above/below/here flags relative to a reference floor.
module elevator_call_reg #(
  parameter int unsigned FLOORS  = 4,
  parameter int unsigned FLOOR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  set_i,
  input  logic [FLOORS-1:0]  clr_i,
  input  logic [FLOOR_W-1:0] ref_floor_i,
  output logic [FLOORS-1:0]  pending_o,
  output logic               here_o,
  output logic               any_above_o,
  output logic               any_below_o
);

  logic [FLOORS-1:0] pending_q, pending_d;

  // Clear beats a simultaneous set: the door is open at that floor, so the call is served.
  always_comb pending_d = (pending_q | set_i) & ~clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  always_comb begin
    here_o      = 1'b0;
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    for (int unsigned f = 0; f < FLOORS; f++) begin
      if (FLOOR_W'(f) == ref_floor_i) here_o      = here_o | pending_q[f];
      if (FLOOR_W'(f) >  ref_floor_i) any_above_o = any_above_o | pending_q[f];
      if (FLOOR_W'(f) <  ref_floor_i) any_below_o = any_below_o | pending_q[f];
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor collective (sweep) elevator controller with door handshake and timed floor tracking.
// Define ELEVATOR_EMERGENCY_EN to add the emerg input (recall to floor 0, door held open).
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned FLOOR_W     = $clog2(FLOORS),
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call,
  input  logic               P,
`ifdef ELEVATOR_EMERGENCY_EN
  input  logic               emerg,
`endif
  output logic [FLOOR_W-1:0] EA,
  output logic [1:0]         Engine,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               dir
);

  localparam int unsigned MC_W = $clog2(MOVE_CYCLES + 1);
  localparam int unsigned DC_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [MC_W-1:0]    MC_LAST = MC_W'(MOVE_CYCLES - 1);
  localparam logic [DC_W-1:0]    DC_LAST = DC_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP     = FLOOR_W'(FLOORS - 1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] ea_q, ea_d, nf, ref_floor;
  logic               dir_q, dir_d;
  logic [MC_W-1:0]    mcnt_q, mcnt_d;
  logic [DC_W-1:0]    dcnt_q, dcnt_d;
  logic [FLOORS-1:0]  set_mask, clr_mask;
  logic               here, any_above, any_below;
  logic               moving, move_term, call_here, go_up, go_dn, ahead, behind, emg;

`ifdef ELEVATOR_EMERGENCY_EN
  assign emg = emerg;
`else
  assign emg = 1'b0;
`endif

  assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DN);
  assign move_term = moving && P && (mcnt_q == MC_LAST);

  always_comb begin
    nf = ea_q;
    if (state_q == MOVE_UP && ea_q != TOP)  nf = ea_q + FLOOR_W'(1);
    if (state_q == MOVE_DN && ea_q != '0)   nf = ea_q - FLOOR_W'(1);
  end

  // Flags are evaluated at the floor being arrived at so the stop decision lands on the same edge.
  assign ref_floor = move_term ? nf : ea_q;

  always_comb begin
    call_here = 1'b0;
    for (int unsigned f = 0; f < FLOORS; f++)
      if (FLOOR_W'(f) == ea_q) call_here = call_here | call[f];
    call_here = call_here & ~emg;
  end

  always_comb begin
    go_up = any_above;
    go_dn = any_below;
    if (any_above && any_below) begin
      go_up = (dir_q == DIR_UP);
      go_dn = (dir_q == DIR_DN);
    end
    ahead  = (state_q == MOVE_UP) ? any_above : any_below;
    behind = (state_q == MOVE_UP) ? any_below : any_above;
  end

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    dir_d   = dir_q;
    mcnt_d  = mcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (emg) begin
          if (ea_q == '0) begin
            state_d = DOOR_OPEN;
            dcnt_d  = '0;
          end else begin
            state_d = MOVE_DN;
            dir_d   = DIR_DN;
          end
        end else if (here) begin
          state_d = DOOR_OPEN;
          dcnt_d  = '0;
        end else if (go_up) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (go_dn) begin
          state_d = MOVE_DN;
          dir_d   = DIR_DN;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (move_term) begin
          mcnt_d = '0;
          ea_d   = nf;
          if (emg) begin
            if (nf == '0) begin
              state_d = DOOR_OPEN;
              dcnt_d  = '0;
            end else begin
              state_d = MOVE_DN;
              dir_d   = DIR_DN;
            end
          end else if (here) begin
            state_d = DOOR_OPEN;
            dcnt_d  = '0;
          end else if (ahead) begin
            state_d = state_q;
          end else if (behind) begin
            state_d = (state_q == MOVE_UP) ? MOVE_DN : MOVE_UP;
            dir_d   = ~dir_q;
          end else begin
            state_d = IDLE;
          end
        end else if (P) begin
          mcnt_d = mcnt_q + MC_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (emg && ea_q == '0) begin
          dcnt_d = '0;
        end else if (call_here) begin
          dcnt_d = '0;
        end else if (dcnt_q == DC_LAST) begin
          state_d = DOOR_CLOSE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DC_W'(1);
        end
      end
      DOOR_CLOSE: begin
        if (emg) begin
          if (P) begin
            if (ea_q == '0) begin
              state_d = DOOR_OPEN;
              dcnt_d  = '0;
            end else begin
              state_d = MOVE_DN;
              dir_d   = DIR_DN;
            end
          end
        end else if (!P && call_here) begin
          state_d = DOOR_OPEN;
          dcnt_d  = '0;
        end else if (P) begin
          if (go_up) begin
            state_d = MOVE_UP;
            dir_d   = DIR_UP;
          end else if (go_dn) begin
            state_d = MOVE_DN;
            dir_d   = DIR_DN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    set_mask = emg ? '0 : call;
    clr_mask = '0;
    for (int unsigned f = 0; f < FLOORS; f++)
      clr_mask[f] = (state_d == DOOR_OPEN) && (FLOOR_W'(f) == ea_d);
    if (emg) clr_mask = '1;
  end

  elevator_call_reg #(
    .FLOORS (FLOORS),
    .FLOOR_W(FLOOR_W)
  ) u_call_reg (
    .clk        (clk),
    .rst_n      (reset),
    .set_i      (set_mask),
    .clr_i      (clr_mask),
    .ref_floor_i(ref_floor),
    .pending_o  (pending),
    .here_o     (here),
    .any_above_o(any_above),
    .any_below_o(any_below)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ea_q    <= '0;
      dir_q   <= DIR_UP;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      dir_q   <= dir_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign EA        = ea_q;
  assign dir       = dir_q;
  assign door_open = (state_q == DOOR_OPEN);
  assign Engine    = {(state_q == MOVE_DN) & P, (state_q == MOVE_UP) & P};

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n: directed scenarios plus randomized run against a reference model.
module tb_elevator_ctrl_n;

  localparam int FL = 4;
  localparam int MC = 3;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call;
  logic       P;
  logic [1:0] EA;
  logic [1:0] Engine;
  logic       door_open;
  logic [3:0] pending;
  logic       dir;
`ifdef ELEVATOR_EMERGENCY_EN
  logic       emerg = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  elevator_ctrl_n #(
    .FLOORS     (FL),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .call     (call),
    .P        (P),
`ifdef ELEVATOR_EMERGENCY_EN
    .emerg    (emerg),
`endif
    .EA       (EA),
    .Engine   (Engine),
    .door_open(door_open),
    .pending  (pending),
    .dir      (dir)
  );

  // Reference model: car position, travel progress and door timer as plain integers.
  typedef enum {PH_REST, PH_TRAVEL, PH_DOORS, PH_LOCKING} phase_t;
  phase_t m_ph;
  int     m_floor, m_dir, m_prog, m_door;
  bit     m_pend[FL];

  function automatic bit m_any(int from, int step);
    for (int g = from + step; g >= 0 && g < FL; g += step)
      if (m_pend[g]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ph = PH_REST; m_floor = 0; m_dir = 0; m_prog = 0; m_door = 0;
    for (int g = 0; g < FL; g++) m_pend[g] = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic p);
    phase_t ph = m_ph;
    int fl = m_floor, d = m_dir, pr = m_prog, dr = m_door;
    bit up, dn, choose;
    choose = 1'b0;
    case (m_ph)
      PH_REST:
        if (m_pend[fl]) begin ph = PH_DOORS; dr = 0; end
        else choose = 1'b1;
      PH_TRAVEL:
        if (p) begin
          if (pr == MC - 1) begin
            pr = 0;
            fl = fl + (d ? -1 : 1);
            if (m_pend[fl]) begin ph = PH_DOORS; dr = 0; end
            else if (m_any(fl, d ? -1 : 1)) ph = PH_TRAVEL;
            else if (m_any(fl, d ? 1 : -1)) d = 1 - d;
            else ph = PH_REST;
          end else pr++;
        end
      PH_DOORS:
        if (c[fl]) dr = 0;
        else if (dr == DC - 1) begin ph = PH_LOCKING; dr = 0; end
        else dr++;
      PH_LOCKING:
        if (!p && c[fl]) begin ph = PH_DOORS; dr = 0; end
        else if (p) begin ph = PH_REST; choose = 1'b1; end
    endcase
    if (choose) begin
      up = m_any(fl, 1);
      dn = m_any(fl, -1);
      if (up && dn) ph = PH_TRAVEL;
      else if (up) begin ph = PH_TRAVEL; d = 0; end
      else if (dn) begin ph = PH_TRAVEL; d = 1; end
    end
    for (int g = 0; g < FL; g++) begin
      if (c[g]) m_pend[g] = 1'b1;
      if (ph == PH_DOORS && g == fl) m_pend[g] = 1'b0;
    end
    m_ph = ph; m_floor = fl; m_dir = d; m_prog = pr; m_door = dr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    call  = '0;
    P     = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    call = 4'b1111; P = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++; if (EA !== 2'd0) begin n_bad++; $display("FAIL reset_EA actual=%0d required=0", EA); end
    n_cmp++; if (Engine !== 2'b00) begin n_bad++; $display("FAIL reset_Engine actual=%b required=00", Engine); end
    n_cmp++; if (door_open !== 1'b0) begin n_bad++; $display("FAIL reset_door actual=%b required=0", door_open); end
    n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL reset_pending actual=%b required=0000", pending); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir actual=%b required=0", dir); end
    do_reset();
  endtask

  task automatic test_single_call();
    int up_n = 0, door_n = 0, prev_ea = 0;
    bit seq_ok = 1'b1, done = 1'b0;
    do_reset();
    call = 4'b0100; cyc(); call = '0;
    n_cmp++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL single_latch actual=%b required=0100", pending); end
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (Engine == 2'b01) up_n++;
      if (door_open) door_n++;
      if (EA !== 2'(prev_ea)) begin
        if (EA !== 2'(prev_ea + 1)) seq_ok = 1'b0;
        prev_ea = int'(EA);
      end
      if (door_n > 0 && !door_open) done = 1'b1;
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL single_timeout actual=no_close required=close"); end
    n_cmp++; if (up_n != 6) begin n_bad++; $display("FAIL single_up_cycles actual=%0d required=6", up_n); end
    n_cmp++; if (!seq_ok || prev_ea != 2) begin n_bad++; $display("FAIL single_floor_seq actual=%0d ok=%0d required=2 ok=1", prev_ea, seq_ok); end
    n_cmp++; if (door_n != DC) begin n_bad++; $display("FAIL single_door_cycles actual=%0d required=%0d", door_n, DC); end
    n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL single_pending actual=%b required=0000", pending); end
  endtask

  task automatic test_reversal();
    int first = -1;
    bit saw_dn = 1'b0, done = 1'b0;
    do_reset();
    call = 4'b1000; cyc(); call = '0;
    for (int i = 0; i < 20 && EA !== 2'd1; i++) cyc();
    n_cmp++; if (EA !== 2'd1 || Engine !== 2'b01) begin n_bad++; $display("FAIL rev_at1 actual=EA%0d Eng%b required=EA1 Eng01", EA, Engine); end
    call = 4'b0001; cyc(); call = '0;
    for (int i = 0; i < 80 && !done; i++) begin
      cyc();
      if (door_open && first < 0) first = int'(EA);
      if (dir === 1'b1 && Engine === 2'b10) saw_dn = 1'b1;
      if (door_open && EA === 2'd0) done = 1'b1;
    end
    n_cmp++; if (first != 3) begin n_bad++; $display("FAIL rev_first_stop actual=%0d required=3", first); end
    n_cmp++; if (!saw_dn) begin n_bad++; $display("FAIL rev_down actual=no_down required=dir1_Eng10"); end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rev_end_floor actual=EA%0d required=EA0_door", EA); end
    n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL rev_pending actual=%b required=0000", pending); end
  endtask

  task automatic test_p_hold();
    int n = 0;
    do_reset();
    call = 4'b0010; cyc(); call = '0;
    cyc();
    n_cmp++; if (Engine !== 2'b01) begin n_bad++; $display("FAIL hold_start actual=%b required=01", Engine); end
    cyc(); n = 1;
    P = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); n++;
      n_cmp++; if ({Engine, EA} !== 4'b0000) begin n_bad++; $display("FAIL hold_frozen actual=Eng%b EA%0d required=Eng00 EA0", Engine, EA); end
    end
    P = 1'b1;
    for (int i = 0; i < 10 && EA !== 2'd1; i++) begin cyc(); n++; end
    n_cmp++; if (n != MC + 5) begin n_bad++; $display("FAIL hold_latency actual=%0d required=%0d", n, MC + 5); end
    n_cmp++; if (door_open !== 1'b1) begin n_bad++; $display("FAIL hold_stop actual=%b required=1", door_open); end
  endtask

  task automatic test_door_recall();
    int open_n = 0;
    bit closed = 1'b0;
    do_reset();
    call = 4'b0010; cyc(); call = '0;
    for (int i = 0; i < 20 && !door_open; i++) cyc();
    cyc();
    call = 4'b0010; cyc(); call = '0;
    for (int i = 0; i < 10 && !closed; i++) begin
      if (door_open) begin open_n++; cyc(); end
      else closed = 1'b1;
    end
    n_cmp++; if (open_n != DC) begin n_bad++; $display("FAIL recall_open_cycles actual=%0d required=%0d", open_n, DC); end
    n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL recall_pending actual=%b required=0000", pending); end
  endtask

  task automatic test_reset_midtravel();
    logic [3:0] pre;
    do_reset();
    call = 4'b1000; cyc(); call = '0;
    for (int i = 0; i < 30 && !door_open; i++) cyc();
    call = 4'b0011; cyc(); call = '0;
    for (int i = 0; i < 40 && !(EA === 2'd2 && Engine === 2'b10); i++) cyc();
    pre = pending;
    n_cmp++; if (pre !== 4'b0011 || Engine !== 2'b10) begin n_bad++; $display("FAIL midrst_setup actual=pend%b Eng%b required=pend0011 Eng10", pre, Engine); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({EA, Engine, door_open, pending, dir} !== 10'd0) begin
      n_bad++; $display("FAIL midrst_clear actual=EA%0d Eng%b door%b pend%b dir%b required=all_zero", EA, Engine, door_open, pending, dir);
    end
    @(negedge clk) reset = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic [3:0] exp_pend;
    logic [1:0] exp_eng;
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      call = ($urandom_range(0, 5) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      P    = ($urandom_range(0, 7) != 0);
      @(posedge clk);
      model_step(call, P);
      #1;
      for (int g = 0; g < FL; g++) exp_pend[g] = m_pend[g];
      exp_eng = (m_ph == PH_TRAVEL && P) ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++; if (EA !== 2'(m_floor)) begin n_bad++; $display("FAIL rnd_EA cyc=%0d actual=%0d required=%0d", i, EA, m_floor); end
      n_cmp++; if (Engine !== exp_eng) begin n_bad++; $display("FAIL rnd_Engine cyc=%0d actual=%b required=%b", i, Engine, exp_eng); end
      n_cmp++; if (door_open !== (m_ph == PH_DOORS)) begin n_bad++; $display("FAIL rnd_door cyc=%0d actual=%b required=%b", i, door_open, m_ph == PH_DOORS); end
      n_cmp++; if (pending !== exp_pend) begin n_bad++; $display("FAIL rnd_pending cyc=%0d actual=%b required=%b", i, pending, exp_pend); end
      n_cmp++; if (dir !== 1'(m_dir)) begin n_bad++; $display("FAIL rnd_dir cyc=%0d actual=%b required=%0d", i, dir, m_dir); end
    end
    call = '0; P = 1'b1;
  endtask

`ifdef ELEVATOR_EMERGENCY_EN
  task automatic test_emergency();
    bit arrived = 1'b0, held = 1'b1;
    do_reset();
    call = 4'b1000; cyc(); call = '0;
    for (int i = 0; i < 30 && !door_open; i++) cyc();
    call = 4'b0011; cyc(); call = '0;
    emerg = 1'b1; cyc();
    n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL emerg_clear actual=%b required=0000", pending); end
    for (int i = 0; i < 60 && !arrived; i++) begin
      cyc();
      if (door_open && EA === 2'd0) arrived = 1'b1;
    end
    n_cmp++; if (!arrived) begin n_bad++; $display("FAIL emerg_arrive actual=EA%0d required=EA0_door", EA); end
    for (int i = 0; i < 10; i++) begin cyc(); if (door_open !== 1'b1) held = 1'b0; end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL emerg_hold actual=closed required=open"); end
    emerg = 1'b0;
    for (int i = 0; i < 10 && door_open; i++) cyc();
    n_cmp++; if (door_open !== 1'b0) begin n_bad++; $display("FAIL emerg_release actual=%b required=0", door_open); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; call = '0; P = 1'b1;
    #12;
    test_reset();
    test_single_call();
    test_reversal();
    test_p_hold();
    test_door_recall();
    test_reset_midtravel();
    test_random();
`ifdef ELEVATOR_EMERGENCY_EN
    test_emergency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
